// File: rtl/axi4_wr_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_wr_pkg
//  Purpose  : Shared types and constants for the AXI4 write responder and
//             the burst address generator it shares with the read side.
//  Contents : burst_e, resp_e, state_e, AXI_4KB
//  Revision : 1.0  initial release
// ============================================================================
package axi4_wr_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned AXI_4KB = 4096;

endpackage
`default_nettype wire

// File: rtl/axi4_wr_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_wr_responder_if
//  Purpose  : AXI4 write-side bundle (AW, W and B channels).
//  Modports : master - drives AW/W payloads and bready
//             slave  - drives awready, wready and the B channel
//  Revision : 1.0  initial release
// ============================================================================
interface axi4_wr_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) ();

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awregion;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awregion, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awregion, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_wr_responder_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_burst_addr_gen
//  Purpose  : Combinational AXI4 next-beat address for FIXED/INCR/WRAP.
//  Ports    : addr      - current beat byte address
//             size      - log2 bytes per beat
//             len       - beats minus 1
//             burst     - burst type
//             next_addr - address of the following beat
//  Revision : 1.0  initial release
// ============================================================================
module axi4_burst_addr_gen
    import axi4_wr_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [2:0]        size,
    input  wire logic [7:0]        len,
    input  wire logic [1:0]        burst,
    output logic      [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_boundary;
    logic [ADDR_W-1:0] w_wrap_base;

    always_comb begin
        w_bytes     = ADDR_W'(1) << size;
        w_aligned   = addr & ~(w_bytes - ADDR_W'(1));
        w_incr      = w_aligned + w_bytes;
        // Wrap window is (len+1)*bytes, always a power of two for legal WRAP
        w_boundary  = (ADDR_W'(len) + ADDR_W'(1)) << size;
        w_wrap_base = addr & ~(w_boundary - ADDR_W'(1));
        next_addr   = addr;
        case (burst_e'(burst))
            INCR:    next_addr = w_incr;
            WRAP:    next_addr = (w_incr == w_wrap_base + w_boundary) ?
                                 w_incr - w_boundary : w_incr;
            default: next_addr = addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi4_wr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_wr_responder
//  Purpose  : AXI4 write subordinate, one burst outstanding, driving a
//             synchronous memory write port.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             axi (slave modport) - AW, W and B channels
//             mem_we/addr/wdata/wstrb - memory write port, one write per
//                                       accepted beat when the burst is OKAY
//  Revision : 1.0  initial release
// ============================================================================
module axi4_wr_responder
    import axi4_wr_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 1,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0001_0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axi4_wr_responder_if.slave axi,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb
);

    localparam logic [2:0] c_max_size = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam int         c_4kb_lsb  = $clog2(AXI_4KB);

    state_e            r_state, w_state_nxt;
    logic              r_awready;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    resp_e             r_err;
    logic              r_wlast_err;
    resp_e             r_bresp;

    logic              w_aw_hs, w_w_hs, w_b_hs;
    logic              w_wready, w_bvalid;
    logic              w_last_beat, w_wlast_bad;
    resp_e             w_final_resp;
    logic [ADDR_W-1:0] w_next_addr;

    logic [ADDR_W-1:0] w_bytes, w_offset, w_last_byte;
    burst_e            w_aw_burst;
    logic              w_aw_slverr;
    resp_e             w_aw_err;

    // Error class of the burst being offered on AW
    always_comb begin
        w_aw_burst  = burst_e'(axi.awburst);
        w_bytes     = ADDR_W'(1) << axi.awsize;
        w_offset    = axi.awaddr - ADDR_BASE;   // below-base wraps to a huge offset
        w_last_byte = (axi.awaddr & ~(w_bytes - ADDR_W'(1)))
                    + ((ADDR_W'(axi.awlen) + ADDR_W'(1)) << axi.awsize)
                    - ADDR_W'(1);
        w_aw_slverr = (w_aw_burst == RSVD)
                   || (axi.awsize > c_max_size)
                   || ((w_aw_burst == WRAP) && !(axi.awlen == 8'd1 || axi.awlen == 8'd3 ||
                                                 axi.awlen == 8'd7 || axi.awlen == 8'd15))
                   || ((w_aw_burst == WRAP) && ((axi.awaddr & (w_bytes - ADDR_W'(1))) != '0))
                   || ((w_aw_burst == INCR) &&
                       (axi.awaddr[ADDR_W-1:c_4kb_lsb] != w_last_byte[ADDR_W-1:c_4kb_lsb]));
        if (w_offset >= ADDR_SIZE)
            w_aw_err = DECERR;
        else if (w_aw_slverr)
            w_aw_err = SLVERR;
        else
            w_aw_err = OKAY;
    end

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_next_addr)
    );

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_state)
            IDLE: if (w_aw_hs) w_state_nxt = DATA;
            DATA: begin
                w_wready = 1'b1;
                if (w_w_hs && w_last_beat) w_state_nxt = RESP;
            end
            RESP: begin
                w_bvalid = 1'b1;
                if (axi.bready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_aw_hs      = axi.awvalid & r_awready;
    assign w_w_hs       = axi.wvalid & w_wready;
    assign w_b_hs       = w_bvalid & axi.bready;
    assign w_last_beat  = (r_cnt == r_len);
    assign w_wlast_bad  = (axi.wlast != w_last_beat);
    // A wlast mismatch only downgrades an otherwise clean burst
    assign w_final_resp = ((r_err == OKAY) && (r_wlast_err || w_wlast_bad)) ? SLVERR : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_awready   <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_err       <= OKAY;
            r_wlast_err <= 1'b0;
            r_bresp     <= OKAY;
        end else begin
            r_state   <= w_state_nxt;
            // Registered ready: high exactly while the next state is IDLE
            r_awready <= (w_state_nxt == IDLE);
            if (w_aw_hs) begin
                r_id        <= axi.awid;
                r_addr      <= axi.awaddr;
                r_len       <= axi.awlen;
                r_size      <= axi.awsize;
                r_burst     <= axi.awburst;
                r_cnt       <= '0;
                r_err       <= w_aw_err;
                r_wlast_err <= 1'b0;
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 8'd1;
                if (w_wlast_bad) r_wlast_err <= 1'b1;
                if (w_last_beat) r_bresp <= w_final_resp;
            end
            if (w_b_hs) r_bresp <= r_bresp;
        end
    end

    assign axi.awready = r_awready;
    assign axi.wready  = w_wready;
    assign axi.bvalid  = w_bvalid;
    assign axi.bid     = r_id;
    assign axi.bresp   = r_bresp;

    assign mem_we    = w_w_hs & (r_err == OKAY);
    assign mem_addr  = r_addr;
    assign mem_wdata = axi.wdata;
    assign mem_wstrb = axi.wstrb;

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_wr_responder
//  Purpose  : Directed self-checking bench for axi4_wr_responder.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_wr_responder;
    import axi4_wr_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;
    int b_count  = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] exp_a[$];

    axi4_wr_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    axi4_wr_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .ADDR_BASE(32'h0000_0000), .ADDR_SIZE(32'h0001_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;

    // Capture every memory write and every B handshake at the active edge
    always @(posedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (axi.bvalid && axi.bready) b_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = size; axi.awburst = burst; axi.awvalid = 1'b1;
        while (!axi.awready && t < 50) begin step(); t++; end
        if (t >= 50) check("aw_timeout", 64'd0, 64'd1);
        step();
        axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic last, input int stall);
        int t = 0;
        axi.wvalid = 1'b0;
        repeat (stall) step();
        axi.wdata = data; axi.wstrb = 4'hF; axi.wlast = last; axi.wvalid = 1'b1;
        while (!axi.wready && t < 50) begin step(); t++; end
        if (t >= 50) check("w_timeout", 64'd0, 64'd1);
        step();
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    // bad < 0: wlast on the final beat; otherwise wlast only on beat index bad
    task automatic run_burst(input string tag, input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] dbase, input int bad, input bit stall,
                             input bit hold_aw, input logic [1:0] exp_resp);
        logic last;
        wq_addr.delete();
        wq_data.delete();
        send_aw(id, addr, len, size, burst);
        check({tag, "_wready_rise"}, 64'(axi.wready), 64'd1);
        check({tag, "_awready_low"}, 64'(axi.awready), 64'd0);
        if (hold_aw) axi.awvalid = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            last = (bad < 0) ? (i == int'(len)) : (i == bad);
            send_w(dbase + 32'(i), last, (stall && i == 1) ? 2 : 0);
            if (hold_aw) check({tag, "_aw_held_off"}, 64'(axi.awready), 64'd0);
        end
        axi.awvalid = 1'b0;
        check({tag, "_bvalid_rise"}, 64'(axi.bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(axi.bresp), 64'(exp_resp));
        check({tag, "_bid"}, 64'(axi.bid), 64'(id));
        if (!axi.bready) begin
            repeat (3) begin
                step();
                check({tag, "_bvalid_hold"}, 64'(axi.bvalid), 64'd1);
                check({tag, "_bresp_hold"}, 64'(axi.bresp), 64'(exp_resp));
            end
            axi.bready = 1'b1;
        end
        step();
        check({tag, "_bvalid_fall"}, 64'(axi.bvalid), 64'd0);
        check({tag, "_awready_back"}, 64'(axi.awready), 64'd1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] dbase);
        int n;
        check({tag, "_nwrites"}, 64'(wq_addr.size()), 64'(exp_a.size()));
        n = (wq_addr.size() < exp_a.size()) ? wq_addr.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 64'(wq_addr[i]), 64'(exp_a[i]));
            check({tag, "_data"}, 64'(wq_data[i]), 64'(dbase + 32'(i)));
        end
    endtask

    initial begin
        int bc;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awregion = '0; axi.awqos = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.wvalid = 1'b0; axi.bready = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_awready", 64'(axi.awready), 64'd0);
        check("rst_wready",  64'(axi.wready),  64'd0);
        check("rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("rst_bid",     64'(axi.bid),     64'd0);
        check("rst_bresp",   64'(axi.bresp),   64'd0);
        check("rst_mem_we",  64'(mem_we),      64'd0);
        rst = 1'b0;
        step();
        check("awready_after_rst", 64'(axi.awready), 64'd1);

        // Single beat
        exp_a = '{32'h100};
        run_burst("single", 1'b1, 32'h100, 8'd0, 3'd2, 2'd1, 32'hDEAD_BEEF, -1, 1'b0, 1'b0, 2'b00);
        check_writes("single", 32'hDEAD_BEEF);

        // INCR 4 beats, then again with a W stall
        exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C};
        run_burst("incr4", 1'b0, 32'h10, 8'd3, 3'd2, 2'd1, 32'h1000, -1, 1'b0, 1'b0, 2'b00);
        check_writes("incr4", 32'h1000);
        run_burst("incr4_stall", 1'b1, 32'h10, 8'd3, 3'd2, 2'd1, 32'h2000, -1, 1'b1, 1'b0, 2'b00);
        check_writes("incr4_stall", 32'h2000);

        // WRAP legal and illegal length
        exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34};
        run_burst("wrap4", 1'b0, 32'h38, 8'd3, 3'd2, 2'd2, 32'h3000, -1, 1'b0, 1'b0, 2'b00);
        check_writes("wrap4", 32'h3000);
        exp_a = {};
        run_burst("wrap3", 1'b0, 32'h0, 8'd2, 3'd2, 2'd2, 32'h0, -1, 1'b0, 1'b0, 2'b10);
        check_writes("wrap3", 32'h0);

        // Outside the decode window
        run_burst("decerr", 1'b1, 32'h0002_0000, 8'd1, 3'd2, 2'd1, 32'h0, -1, 1'b0, 1'b0, 2'b11);
        check_writes("decerr", 32'h0);

        // FIXED, with awvalid asserted during the burst
        exp_a = '{32'h40, 32'h40, 32'h40};
        run_burst("fixed", 1'b0, 32'h40, 8'd2, 3'd2, 2'd0, 32'h4000, -1, 1'b0, 1'b1, 2'b00);
        check_writes("fixed", 32'h4000);

        // Early wlast, then a clean burst, then a missing wlast
        exp_a = '{32'h200, 32'h204};
        run_burst("early_wlast", 1'b1, 32'h200, 8'd1, 3'd2, 2'd1, 32'h5000, 0, 1'b0, 1'b0, 2'b10);
        check_writes("early_wlast", 32'h5000);
        exp_a = '{32'h300};
        run_burst("after_wlast", 1'b0, 32'h300, 8'd0, 3'd2, 2'd1, 32'h6000, -1, 1'b0, 1'b0, 2'b00);
        check_writes("after_wlast", 32'h6000);
        exp_a = '{32'h700, 32'h704};
        run_burst("no_wlast", 1'b0, 32'h700, 8'd1, 3'd2, 2'd1, 32'h6100, 9, 1'b0, 1'b0, 2'b10);
        check_writes("no_wlast", 32'h6100);

        // 256-beat burst
        exp_a = {};
        for (int i = 0; i < 256; i++) exp_a.push_back(32'h400 + 32'(4 * i));
        run_burst("len255", 1'b1, 32'h400, 8'd255, 3'd2, 2'd1, 32'h0, -1, 1'b0, 1'b0, 2'b00);
        check_writes("len255", 32'h0);

        // INCR crossing 4KB; beat size wider than the bus
        exp_a = {};
        run_burst("cross4k", 1'b0, 32'hFF0, 8'd7, 3'd2, 2'd1, 32'h0, -1, 1'b0, 1'b0, 2'b10);
        check_writes("cross4k", 32'h0);
        run_burst("size8", 1'b0, 32'h500, 8'd0, 3'd3, 2'd1, 32'h0, -1, 1'b0, 1'b0, 2'b10);
        check_writes("size8", 32'h0);

        // bready low when bvalid rises
        axi.bready = 1'b0;
        exp_a = '{32'h600, 32'h604};
        run_burst("bready_late", 1'b1, 32'h600, 8'd1, 3'd2, 2'd1, 32'h7000, -1, 1'b0, 1'b0, 2'b00);
        check_writes("bready_late", 32'h7000);

        // Reset in the middle of a burst
        wq_addr.delete();
        wq_data.delete();
        bc = b_count;
        send_aw(1'b1, 32'h80, 8'd3, 3'd2, 2'd1);
        send_w(32'h8000, 1'b0, 0);
        rst = 1'b1;
        step();
        check("midrst_awready", 64'(axi.awready), 64'd0);
        check("midrst_wready",  64'(axi.wready),  64'd0);
        check("midrst_bvalid",  64'(axi.bvalid),  64'd0);
        rst = 1'b0;
        step();
        check("midrst_awready_back", 64'(axi.awready), 64'd1);
        check("midrst_wready_idle",  64'(axi.wready),  64'd0);
        repeat (3) step();
        check("midrst_no_b", 64'(b_count), 64'(bc));
        exp_a = '{32'h80};
        check_writes("midrst", 32'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
